// File: rtl/miner_pkg.sv
// Shared constants and state type for the miner work-sequencing controller.
//   WORK_WORDS     : words per work unit (midstate + block tail)
//   MIDSTATE_WORDS : 32-bit words of SHA-256 midstate
//   DATA_WORDS     : 32-bit words of block tail
//   NONCE_LAST     : final nonce issued before draining
package miner_pkg;

  localparam int unsigned WORK_WORDS     = 11;
  localparam int unsigned MIDSTATE_WORDS = 8;
  localparam int unsigned DATA_WORDS     = 3;
  localparam logic [31:0] NONCE_LAST     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/work_loader.sv
// Captures an 11-word work unit from the host word stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ready       : word strobe, serial_in valid when high
//   serial_in   : 32-bit work word
//   midstate    : words 0..7, word 0 in the low 32 bits
//   data        : words 8..10, word 8 in the low 32 bits
//   load_start  : pulse, first word of a unit is being accepted
//   load_done   : pulse, last word of a unit is being accepted
module work_loader
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [31:0]  serial_in,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic         load_start,
  output logic         load_done
);

  localparam logic [3:0] WcLast = 4'(WORK_WORDS - 1);

  logic [3:0]   wc_q, wc_d;
  logic [255:0] midstate_q, midstate_d;
  logic [95:0]  data_q, data_d;

  always_comb begin
    wc_d       = wc_q;
    midstate_d = midstate_q;
    data_d     = data_q;
    if (ready) begin
      for (int unsigned i = 0; i < MIDSTATE_WORDS; i++) begin
        if (wc_q == 4'(i)) midstate_d[32*i +: 32] = serial_in;
      end
      for (int unsigned i = 0; i < DATA_WORDS; i++) begin
        if (wc_q == 4'(MIDSTATE_WORDS + i)) data_d[32*i +: 32] = serial_in;
      end
      wc_d = (wc_q == WcLast) ? 4'd0 : wc_q + 4'd1;
    end
  end

  assign load_start = ready && (wc_q == 4'd0);
  assign load_done  = ready && (wc_q == WcLast);
  assign midstate   = midstate_q;
  assign data       = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc_q       <= '0;
      midstate_q <= '0;
      data_q     <= '0;
    end else begin
      wc_q       <= wc_d;
      midstate_q <= midstate_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/miner_work_ctrl.sv
// Work-sequencing controller in front of the SHA-256 double-hash core.
// Loads a work unit, issues nonces at the core's accept rate, filters results
// and reports the first golden nonce.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ready, serial_in    : host work-word stream
//   hit, serial_out     : sticky golden-nonce flag and nonce
//   busy, exhausted     : LOAD/RUN indicator, nonce space spent without a hit
//   core_midstate/data  : work unit to the core
//   core_issue/nonce    : nonce hand-off to the core
//   core_result_*       : result stream from the core
module miner_work_ctrl
  import miner_pkg::*;
#(
  parameter int unsigned LOOP_LOG2      = 5,
  parameter int unsigned RESULT_LATENCY = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [31:0]  serial_in,
  output logic         hit,
  output logic [31:0]  serial_out,
  output logic         busy,
  output logic         exhausted,
  output logic [255:0] core_midstate,
  output logic [95:0]  core_data,
  output logic         core_issue,
  output logic [31:0]  core_nonce,
  input  logic         core_result_valid,
  input  logic         core_result_hit,
  input  logic [31:0]  core_result_nonce
);

  localparam int unsigned IcW  = (LOOP_LOG2 == 0) ? 1 : LOOP_LOG2;
  localparam int unsigned LatW = $clog2(RESULT_LATENCY + 1);
  localparam logic [LatW-1:0] LatInit = LatW'(RESULT_LATENCY);

  logic load_start, load_done;

  work_loader u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready),
    .serial_in  (serial_in),
    .midstate   (core_midstate),
    .data       (core_data),
    .load_start (load_start),
    .load_done  (load_done)
  );

  state_e          state_q, state_d;
  logic [31:0]     nonce_q, nonce_d;
  logic [IcW-1:0]  ic_q, ic_d;
  logic [LatW-1:0] bc_q, bc_d;
  logic [LatW-1:0] dc_q, dc_d;
  logic            hit_q, hit_d;
  logic [31:0]     serial_out_q, serial_out_d;
  logic            exhausted_q, exhausted_d;
  logic            issue, accept, golden;

  // A host word in the same cycle suppresses both issue and result acceptance.
  assign issue  = (state_q == StRun) && (ic_q == '0) && !ready;
  // bc blanks results still in flight from the previous work unit.
  assign accept = core_result_valid && (state_q inside {StRun, StDrain}) &&
                  (bc_q == '0) && !hit_q && !ready;
  assign golden = accept && core_result_hit;

  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    ic_d         = ic_q;
    bc_d         = bc_q;
    dc_d         = dc_q;
    hit_d        = hit_q;
    serial_out_d = serial_out_q;
    exhausted_d  = exhausted_q;

    if (load_start) begin
      state_d      = StLoad;
      hit_d        = 1'b0;
      serial_out_d = '0;
      exhausted_d  = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_done) begin
            state_d = StRun;
            nonce_d = '0;
            ic_d    = '0;
            bc_d    = LatInit;
          end
        end
        StRun: begin
          if (bc_q != '0) bc_d = bc_q - LatW'(1);
          if (LOOP_LOG2 != 0) ic_d = ic_q + IcW'(1);
          if (issue) begin
            if (nonce_q == NONCE_LAST) begin
              state_d = StDrain;
              dc_d    = LatInit;
            end else begin
              nonce_d = nonce_q + 32'd1;
            end
          end
          if (golden) begin
            hit_d        = 1'b1;
            serial_out_d = core_result_nonce;
            state_d      = StDone;
          end
        end
        StDrain: begin
          if (golden) begin
            hit_d        = 1'b1;
            serial_out_d = core_result_nonce;
            state_d      = StDone;
          end else if (dc_q == '0) begin
            exhausted_d = 1'b1;
            state_d     = StDone;
          end else begin
            dc_d = dc_q - LatW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      nonce_q      <= '0;
      ic_q         <= '0;
      bc_q         <= '0;
      dc_q         <= '0;
      hit_q        <= 1'b0;
      serial_out_q <= '0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      nonce_q      <= nonce_d;
      ic_q         <= ic_d;
      bc_q         <= bc_d;
      dc_q         <= dc_d;
      hit_q        <= hit_d;
      serial_out_q <= serial_out_d;
      exhausted_q  <= exhausted_d;
    end
  end

  assign hit        = hit_q;
  assign serial_out = serial_out_q;
  assign exhausted  = exhausted_q;
  assign busy       = (state_q == StLoad) || (state_q == StRun);
  assign core_issue = issue;
  assign core_nonce = nonce_q;

endmodule

// File: tb/tb_miner_work_ctrl.sv
// Directed-plus-random bench for miner_work_ctrl with a latency-accurate core
// model and an issue scoreboard. A second instance runs with LOOP_LOG2=0.
module tb_miner_work_ctrl;

  localparam int unsigned LL  = 5;
  localparam int unsigned RL  = 64;
  localparam int          GAP = 1 << LL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ready = 1'b0;
  logic [31:0]  serial_in = '0;
  logic         crv = 1'b0, crh = 1'b0;
  logic [31:0]  crn = '0;
  logic         z1 = 1'b0;
  logic [31:0]  z32 = '0;

  logic         hit, busy, exhausted, core_issue;
  logic [31:0]  serial_out, core_nonce;
  logic [255:0] core_midstate;
  logic [95:0]  core_data;

  logic         hit0, busy0, exhausted0, core_issue0;
  logic [31:0]  serial_out0, core_nonce0;
  logic [255:0] core_midstate0;
  logic [95:0]  core_data0;

  miner_work_ctrl #(.LOOP_LOG2(LL), .RESULT_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .serial_in(serial_in),
    .hit(hit), .serial_out(serial_out), .busy(busy), .exhausted(exhausted),
    .core_midstate(core_midstate), .core_data(core_data),
    .core_issue(core_issue), .core_nonce(core_nonce),
    .core_result_valid(crv), .core_result_hit(crh), .core_result_nonce(crn)
  );

  miner_work_ctrl #(.LOOP_LOG2(0), .RESULT_LATENCY(RL)) dut0 (
    .clk(clk), .rst_n(rst_n), .ready(ready), .serial_in(serial_in),
    .hit(hit0), .serial_out(serial_out0), .busy(busy0), .exhausted(exhausted0),
    .core_midstate(core_midstate0), .core_data(core_data0),
    .core_issue(core_issue0), .core_nonce(core_nonce0),
    .core_result_valid(z1), .core_result_hit(z1), .core_result_nonce(z32)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core model and scoreboard state
  int          due_q[$];
  logic [31:0] non_q[$];
  logic [31:0] gold_q[$];
  logic [31:0] exp_nonce = '0;
  int          last_issue = -1;
  bit          wrapped = 1'b0;
  int          n_issue = 0;
  bit          run0 = 1'b0;
  logic [31:0] exp0 = '0;

  function automatic bit is_gold(input logic [31:0] n);
    foreach (gold_q[i]) if (gold_q[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  // Core model: returns each issued nonce RL cycles later, hit if golden.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      crv = 1'b0; crh = 1'b0; crn = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        crv = 1'b1;
        crn = non_q[0];
        crh = is_gold(non_q[0]);
        void'(due_q.pop_front());
        void'(non_q.pop_front());
      end
      if (rst_n && core_issue) begin
        due_q.push_back(cyc + RL);
        non_q.push_back(core_nonce);
        chk("issue_nonce", core_nonce, exp_nonce);
        chk("issue_after_last", wrapped, 0);
        if (last_issue >= 0) chk("issue_gap", cyc - last_issue, GAP);
        if (exp_nonce == 32'hFFFF_FFFF) wrapped = 1'b1;
        exp_nonce++;
        last_issue = cyc;
        n_issue++;
      end
      if (run0) begin
        chk("dut0_issue", core_issue0, 1);
        chk("dut0_nonce", core_nonce0, exp0);
        exp0++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_work(input logic [31:0] w[11], input int pause_after,
                           input int pause_len, output int t_first);
    logic [255:0] ems;
    logic [95:0]  eda;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == pause_after) begin
        ready = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          #1;
          chk("pause_busy", busy, 1);
          chk("pause_no_issue", core_issue, 0);
          step();
        end
      end
      ready = 1'b1;
      serial_in = w[i];
      if (i == 0) begin
        run0 = 1'b0; exp_nonce = '0; last_issue = -1; wrapped = 1'b0;
      end
    end
    step();
    ready = 1'b0;
    serial_in = $urandom;
    run0 = 1'b1;
    exp0 = '0;
    #1;
    t_first = cyc;
    for (int i = 0; i < 8; i++) ems[32*i +: 32] = w[i];
    for (int i = 0; i < 3; i++) eda[32*i +: 32] = w[8+i];
    chk("first_issue", core_issue, 1);
    chk("first_nonce", core_nonce, 0);
    chk("run_busy", busy, 1);
    chk("load_hit_clear", hit, 0);
    chk("load_midstate", core_midstate, ems);
    chk("load_data", core_data, eda);
  endtask

  logic [31:0] w[11];
  int t_first, n_snap, k, d;
  bit saw;

  initial begin
    #500000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) step();
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_serial_out", serial_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_midstate", core_midstate, 0);
    chk("rst_data", core_data, 0);
    chk("rst_issue", core_issue, 0);
    chk("rst_nonce", core_nonce, 0);
    step();
    rst_n = 1'b1;
    step();

    // Load 1..11, golden nonce 0x2A (0x2B a later, ignored hit)
    gold_q = '{32'h2A, 32'h2B};
    for (int i = 0; i < 11; i++) w[i] = 32'(i + 1);
    load_work(w, -1, 0, t_first);
    chk("ms_word0", core_midstate[31:0], 32'd1);
    chk("ms_word7", core_midstate[255:224], 32'd8);
    chk("data_words", core_data, {32'hB, 32'hA, 32'h9});
    for (k = 0; k < 3000 && !hit; k++) step();
    chk("golden_hit", hit, 1);
    chk("golden_latency", cyc, t_first + 42 * GAP + RL + 1);
    chk("golden_nonce", serial_out, 32'h2A);
    chk("golden_busy", busy, 0);
    chk("golden_exhausted", exhausted, 0);
    n_snap = n_issue;
    repeat (4 * GAP) step();
    chk("done_no_issue", n_issue, n_snap);
    chk("second_hit_ignored", serial_out, 32'h2A);
    chk("hit_sticky", hit, 1);

    // Reload mid-run while stale hits (nonces 2, 3) are still in flight
    gold_q = '{32'h2, 32'h3};
    for (int i = 0; i < 11; i++) w[i] = $urandom;
    load_work(w, -1, 0, t_first);
    for (k = 0; k < 400 && exp_nonce != 32'd4; k++) step();
    chk("reached_nonce3", exp_nonce, 4);
    for (int i = 0; i < 11; i++) w[i] = $urandom;
    load_work(w, -1, 0, t_first);
    saw = 1'b0;
    for (int i = 0; i < 90; i++) begin
      step();
      if (hit) saw = 1'b1;
    end
    chk("blank_no_stale_hit", saw, 0);
    for (k = 0; k < 200 && !hit; k++) step();
    chk("fresh_hit", hit, 1);
    chk("fresh_latency", cyc, t_first + 2 * GAP + RL + 1);
    chk("fresh_nonce", serial_out, 32'h2);

    // Exhaustion, loaded with a 3-cycle pause after 5 words
    gold_q.delete();
    for (int i = 0; i < 11; i++) w[i] = $urandom;
    load_work(w, 5, 3, t_first);
    step();
    force dut.nonce_q = 32'hFFFF_FFFE;
    exp_nonce = 32'hFFFF_FFFE;
    n_snap = n_issue;
    step();
    release dut.nonce_q;
    for (k = 0; k < 300 && !exhausted; k++) step();
    chk("exhausted", exhausted, 1);
    chk("exh_busy", busy, 0);
    chk("exh_hit", hit, 0);
    chk("exh_issue_count", n_issue - n_snap, 2);
    d = cyc - last_issue;
    chk("drain_length", (d >= int'(RL)) && (d <= int'(RL) + 3), 1);
    repeat (40) step();
    chk("exh_no_issue", n_issue - n_snap, 2);

    // Asynchronous reset mid-run
    for (int i = 0; i < 11; i++) w[i] = $urandom;
    load_work(w, -1, 0, t_first);
    repeat (20) step();
    run0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_issue", core_issue, 0);
    chk("mid_rst_nonce", core_nonce, 0);
    chk("mid_rst_midstate", core_midstate, 0);
    chk("mid_rst_data", core_data, 0);
    chk("mid_rst_hit", hit, 0);
    due_q.delete();
    non_q.delete();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
